// File: rtl/sliding_window_buffer.sv
// Sliding KERNEL_SIZE x KERNEL_SIZE window generator over a raster-order pixel stream.
// Keeps the previous K-1 lines and emits a registered window only where it lies fully inside the image.
module sliding_window_buffer #(
  parameter int KERNEL_SIZE  = 3,
  parameter int WORD_SIZE    = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic signed [WORD_SIZE-1:0]                            pixel_in,
  input  logic                                                   pixel_valid,
  input  logic                                                   frame_start,
  output logic signed [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][WORD_SIZE-1:0] window_out,
  output logic                                                   window_valid,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]                        window_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]                         window_col
);
  localparam int K    = KERNEL_SIZE;
  localparam int RW   = $clog2(IMAGE_HEIGHT);
  localparam int CW   = $clog2(IMAGE_WIDTH);
  localparam int HALF = (K - 1) / 2;

  logic [WORD_SIZE-1:0]                 line_q [K-1][IMAGE_WIDTH];
  logic [K-1:0][K-1:0][WORD_SIZE-1:0]   win_q, win_d;
  logic                                 valid_q, valid_d;
  logic [RW-1:0]                        wrow_q, wrow_d;
  logic [CW-1:0]                        wcol_q, wcol_d;
  logic [RW-1:0]                        row_q, row_d, cur_row;
  logic [CW-1:0]                        col_q, col_d, cur_col;
  logic [K-1:0][WORD_SIZE-1:0]          col_vec;

  // frame_start re-anchors the accepted pixel at (0,0) regardless of the counters
  always_comb begin
    cur_row      = frame_start ? '0 : row_q;
    cur_col      = frame_start ? '0 : col_q;
    col_vec[K-1] = pixel_in;
    for (int i = 1; i < K; i++) begin
      col_vec[K-1-i] = line_q[i-1][cur_col];
    end
  end

  always_comb begin
    win_d   = win_q;
    valid_d = 1'b0;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    row_d   = row_q;
    col_d   = col_q;
    if (pixel_valid) begin
      for (int x = 0; x < K; x++) begin
        for (int y = 0; y < K - 1; y++) begin
          win_d[x][y] = win_q[x][y+1];
        end
        win_d[x][K-1] = col_vec[x];
      end
      valid_d = (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));
      wrow_d  = cur_row - RW'(HALF);
      wcol_d  = cur_col - CW'(HALF);
      if (cur_col == CW'(IMAGE_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMAGE_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q   <= '0;
      valid_q <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      win_q   <= win_d;
      valid_q <= valid_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Line storage is never reset; valid gating keeps stale contents out of emitted windows
  always_ff @(posedge clk) begin
    if (!reset && pixel_valid) begin
      line_q[0][cur_col] <= pixel_in;
      for (int i = 1; i < K - 1; i++) begin
        line_q[i][cur_col] <= line_q[i-1][cur_col];
      end
    end
  end

  assign window_out   = win_q;
  assign window_valid = valid_q;
  assign window_row   = wrow_q;
  assign window_col   = wcol_q;

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Randomized bench for sliding_window_buffer on a 4x4 image with a 3x3 kernel.
// Expected windows come from an image-array model indexed by (row, col).
module tb_sliding_window_buffer;
  localparam int K  = 3;
  localparam int W  = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int WB = K * K * W;

  logic                              clk = 1'b0;
  logic                              reset = 1'b1;
  logic                              pixel_valid = 1'b0;
  logic                              frame_start = 1'b0;
  logic signed [W-1:0]               pixel_in = '0;
  logic signed [K-1:0][K-1:0][W-1:0] window_out;
  logic                              window_valid;
  logic [1:0]                        window_row;
  logic [1:0]                        window_col;

  always #5 clk = ~clk;

  sliding_window_buffer #(
    .KERNEL_SIZE (K),
    .WORD_SIZE   (W),
    .IMAGE_WIDTH (IW),
    .IMAGE_HEIGHT(IH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .frame_start (frame_start),
    .window_out  (window_out),
    .window_valid(window_valid),
    .window_row  (window_row),
    .window_col  (window_col)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: the image as written so far, plus the current raster position
  logic [W-1:0]  img [IH][IW];
  int            m_r = 0, m_c = 0;
  bit            exp_valid = 1'b0;
  bit            win_known = 1'b0;
  bit            crd_known = 1'b0;
  logic [WB-1:0] exp_win = '0;
  int            exp_row = 0, exp_col = 0;
  int            pulses = 0;

  function automatic logic [WB-1:0] win_at(input int r0, input int c0);
    logic [WB-1:0] v;
    v = '0;
    for (int x = 0; x < K; x++)
      for (int y = 0; y < K; y++)
        v[(x*K+y)*W +: W] = W'(IW * (r0 + x) + (c0 + y));
    return v;
  endfunction

  task automatic cycle(input bit v, input bit fs, input logic [W-1:0] pix, input bit rst);
    int r, c;
    @(negedge clk);
    reset       = rst;
    pixel_valid = v;
    frame_start = fs;
    pixel_in    = pix;
    if (rst) begin
      exp_valid = 1'b0; win_known = 1'b1; exp_win = '0;
      crd_known = 1'b1; exp_row = 0; exp_col = 0;
      m_r = 0; m_c = 0;
    end else if (v) begin
      r = fs ? 0 : m_r;
      c = fs ? 0 : m_c;
      img[r][c] = pix;
      if (r >= K - 1 && c >= K - 1) begin
        exp_valid = 1'b1; win_known = 1'b1; crd_known = 1'b1;
        for (int x = 0; x < K; x++)
          for (int y = 0; y < K; y++)
            exp_win[(x*K+y)*W +: W] = img[r-(K-1)+x][c-(K-1)+y];
        exp_row = r - (K - 1) / 2;
        exp_col = c - (K - 1) / 2;
      end else begin
        exp_valid = 1'b0; win_known = 1'b0; crd_known = 1'b0;
      end
      c++;
      if (c == IW) begin
        c = 0;
        r++;
        if (r == IH) r = 0;
      end
      m_r = r; m_c = c;
    end else begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check("valid", WB'(window_valid), WB'(exp_valid));
    if (window_valid) pulses++;
    if (win_known) check("window", WB'(window_out), exp_win);
    if (crd_known) begin
      check("row", WB'(window_row), WB'(exp_row));
      check("col", WB'(window_col), WB'(exp_col));
    end
  endtask

  // One frame (or partial frame) of npix pixels; pixel value = raster index unless randomized
  task automatic frame(input bit fs, input int gap_pct, input bit gap9, input int npix,
                       input bit rand_pix, input bit directed);
    logic [W-1:0] pix;
    pulses = 0;
    for (int p = 0; p < npix; p++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
        repeat ($urandom_range(1, 3)) cycle(1'b0, 1'($urandom_range(0, 1)), W'($urandom), 1'b0);
      pix = rand_pix ? W'($urandom) : W'(p);
      cycle(1'b1, fs && (p == 0), pix, 1'b0);
      if (directed) begin
        if (p == 10) begin
          check("first_win", WB'(window_out), win_at(0, 0));
          check("first_rc", WB'({window_row, window_col}), WB'(4'b0101));
        end
        if (p == 11) begin
          check("second_win", WB'(window_out), win_at(0, 1));
          check("second_rc", WB'({window_row, window_col}), WB'(4'b0110));
        end
        if (p == 15) begin
          check("last_win", WB'(window_out), win_at(1, 1));
          check("last_rc", WB'({window_row, window_col}), WB'(4'b1010));
        end
      end
      if (gap9 && p == 9) repeat (3) cycle(1'b0, 1'b0, W'($urandom), 1'b0);
    end
    if (npix == IH * IW) check("pulses", WB'(pulses), WB'((IH - K + 1) * (IW - K + 1)));
  endtask

  initial begin
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, 8'h55, 1'b1);
    check("rst_valid", WB'(window_valid), '0);
    check("rst_win", WB'(window_out), '0);
    check("rst_rc", WB'({window_row, window_col}), '0);

    frame(1'b1, 0, 1'b0, 16, 1'b0, 1'b1);
    frame(1'b0, 0, 1'b0, 16, 1'b0, 1'b1);
    frame(1'b1, 25, 1'b1, 16, 1'b0, 1'b1);

    frame(1'b1, 0, 1'b0, 6, 1'b0, 1'b0);
    frame(1'b1, 0, 1'b0, 16, 1'b0, 1'b1);

    frame(1'b1, 0, 1'b0, 11, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h7f, 1'b1);
    check("rst_mid_valid", WB'(window_valid), '0);
    check("rst_mid_win", WB'(window_out), '0);
    frame(1'b0, 0, 1'b0, 16, 1'b0, 1'b1);

    for (int f = 0; f < 8; f++) begin
      frame(1'($urandom_range(0, 1)), 30, 1'b0, 16, 1'b1, 1'b0);
      if (f == 4) frame(1'b1, 20, 1'b0, int'($urandom_range(1, 15)), 1'b1, 1'b0);
      if (f == 4) frame(1'b1, 20, 1'b0, 16, 1'b1, 1'b0);
    end
    repeat (3) cycle(1'b0, 1'b0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sliding_window_buffer.md
Name: sliding_window_buffer

Overview:
- Streaming producer of KERNEL_SIZE x KERNEL_SIZE pixel windows for the kernel convolution datapath.
- Takes a raster-order stream of signed single-channel pixels, one per accepted cycle.
- Stores the previous KERNEL_SIZE-1 image lines internally.
- Emits a registered window, indexed [row][col] in the same orientation the convolution consumes, each time the window lies fully inside the image (valid-region only, no padding).

Parameters:
- KERNEL_SIZE, 3, window edge length; odd, >= 2.
- WORD_SIZE, 8, bits per signed pixel.
- IMAGE_WIDTH, 640, pixels per line; must be >= KERNEL_SIZE.
- IMAGE_HEIGHT, 480, lines per frame; must be >= KERNEL_SIZE.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- pixel_in  input  signed WORD_SIZE  incoming pixel.
- pixel_valid  input  1  pixel_in is accepted this cycle. No backpressure.
- frame_start  input  1  qualified by pixel_valid; this pixel is (row 0, col 0).
- window_out  output  signed WORD_SIZE [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0]  window; [0][0] = top-left (oldest), [K-1][K-1] = newest pixel.
- window_valid  output  1  window_out holds a complete in-image window this cycle.
- window_row  output  $clog2(IMAGE_HEIGHT)  image row of window centre.
- window_col  output  $clog2(IMAGE_WIDTH)  image column of window centre.

Behaviour:
- Reset (synchronous, dominant over all inputs):
  - window_out all zero, window_valid=0, window_row=0, window_col=0.
  - Internal row/col counters = 0.
  - Line-buffer contents need not be cleared; valid gating guarantees they are never exposed.
- Storage:
  - KERNEL_SIZE-1 line buffers of IMAGE_WIDTH words (register array or inferred RAM with same-cycle read of the old value).
  - K x K window shift register.
- Accepted pixel (pixel_valid=1) at coordinate (r,c), where (r,c)=(0,0) if frame_start=1, else the counters:
  - Column vector: entry K-1 = pixel_in; entry K-1-i = line buffer i-1 at column c, for i=1..K-1 (line buffer 0 = previous line).
  - Window shift: window_out[x][y] <= window_out[x][y+1] for y<K-1; window_out[x][K-1] <= column vector entry x.
  - Line buffer 0 at c <= pixel_in; line buffer i at c <= line buffer i-1 at c (old values).
  - window_valid <= (r >= K-1) && (c >= K-1).
  - window_row <= r-(K-1)/2; window_col <= c-(K-1)/2.
  - Counter advance: c+1; at c=IMAGE_WIDTH-1, c=0 and r+1; at last pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1), r=c=0 (auto-wrap to next frame).
- Latency: window_valid asserts the cycle after the completing pixel is accepted; one-cycle pulse per window.
- pixel_valid=0 cycles: window_out, window_row, window_col hold; window_valid <= 0; counters hold. Gaps of any length are legal, including mid-line.
- frame_start with pixel_valid mid-frame: current frame abandoned; pixel is (0,0); no window emitted until (K-1,K-1) of the new frame.
- frame_start without pixel_valid: ignored.
- Line wrap: windows are never emitted for c < K-1, so columns from the previous line never appear in a valid window.
- Window count: exactly (IMAGE_HEIGHT-K+1)*(IMAGE_WIDTH-K+1) window_valid pulses per uninterrupted frame.
- Width rules:
  - Pixels stored and passed unmodified (signed, WORD_SIZE bits); no arithmetic on data.
  - Coordinate outputs unsigned, computed only when valid; their value on non-valid cycles is don't-care but must hold.

Test Plan:
1. K=3, W=4, H=4; frame_start on the first pixel; continuous pixel_valid; pixel = 4*row+col.
   - 1st window_valid the cycle after pixel 10.
   - window_out = [[0,1,2],[4,5,6],[8,9,10]], centre (1,1).
   - Next window (pixel 11) = [[1,2,3],[5,6,7],[9,10,11]], centre (1,2).
2. Same frame, pixel 15 accepted:
   - Window = [[5,6,7],[9,10,11],[13,14,15]], centre (2,2).
   - Exactly 4 pulses per frame; no pulse for pixels 12 or 13.
3. Two back-to-back frames without a second frame_start:
   - Counters auto-wrap; second frame produces identical 4 windows with identical coordinates.
4. Same stream as test 1 with pixel_valid deasserted for 3 cycles after pixel 9 and randomly elsewhere:
   - Identical window sequence and values as test 1.
   - window_valid never asserted during gaps; outputs hold across gaps.
5. frame_start asserted on the 7th pixel of a frame, then a full 16-pixel frame:
   - No window emitted from stale data; first window equals test 1's first window.
6. reset pulsed for 1 cycle after pixel 10:
   - Next cycle: window_valid=0 and window_out all zero.
   - A subsequent full frame reproduces test 1 exactly.
